// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared memory bus address map, requester indices and arbiter widths
package mem_bus_pkg;

  localparam int unsigned MEMORY_SIZE = 32'h0001_0000;

  localparam logic [31:0] ADDRESS_MTIME           = 32'h8000_0000;
  localparam logic [31:0] ADDRESS_MTIMEH          = 32'h8000_0004;
  localparam logic [31:0] ADDRESS_MTIMECMP        = 32'h8000_0008;
  localparam logic [31:0] ADDRESS_MTIMECMPH       = 32'h8000_000C;
  localparam logic [31:0] ADDRESS_LED             = 32'h8000_0010;
  localparam logic [31:0] ADDRESS_USB_CONTROL     = 32'h8000_0020;
  localparam logic [31:0] ADDRESS_USB_DATA_BUFFER = 32'hC000_0000;
  localparam int unsigned USB_DATA_BUFFER_SIZE    = 1024;

  // Requester indices double as the value stored in last_grant / resp_owner.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_USB = 1'b1;

  localparam int STREAK_WIDTH = 8;

endpackage

// File: rtl/mem_bus_grant.sv
// rtl/mem_bus_grant.sv - contention decision with last_grant and streak registers
// Build option: ARBITER_ROUND_ROBIN_EN selects round-robin; default is fixed priority to requester 0.
module mem_bus_grant
  import mem_bus_pkg::*;
#(
  parameter int MAX_STREAK = 8
) (
  input  logic clk24,
  input  logic reset,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic grant0,
  output logic grant1
);

  localparam logic [STREAK_WIDTH-1:0] STREAK_LIMIT = MAX_STREAK[STREAK_WIDTH-1:0];
  localparam logic [STREAK_WIDTH-1:0] STREAK_ONE   = {{(STREAK_WIDTH-1){1'b0}}, 1'b1};

  logic                    last_grant;
  logic [STREAK_WIDTH-1:0] streak;
  logic                    contended;
  logic                    preferred;
  logic                    guard_hit;
  logic                    winner;

  always_comb begin
    contended = req0_valid && req1_valid;
`ifdef ARBITER_ROUND_ROBIN_EN
    preferred = ~last_grant;
`else
    preferred = REQ_CPU;
`endif
    // Once one requester has won MAX_STREAK contended cycles in a row, the other gets one turn.
    guard_hit = (streak >= STREAK_LIMIT) && (preferred == last_grant);
    winner    = guard_hit ? ~last_grant : preferred;

    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (contended) begin
        grant0 = (winner == REQ_CPU);
        grant1 = (winner == REQ_USB);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      last_grant <= REQ_USB;
      streak     <= '0;
    end else if (contended) begin
      last_grant <= winner;
      streak     <= (winner == last_grant) ? streak + STREAK_ONE : STREAK_ONE;
    end else if (req0_valid || req1_valid) begin
      last_grant <= req1_valid ? REQ_USB : REQ_CPU;
      streak     <= '0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester single-port memory bus arbiter with 1-cycle read return
// Build option: ARBITER_ROUND_ROBIN_EN (forwarded to mem_bus_grant) selects round-robin contention.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_STREAK    = 8
) (
  input  logic                     clk24,
  input  logic                     reset,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [ADDRESS_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0]    req0_write_value,
  input  logic [DATA_WIDTH/8-1:0]  req0_write_sections,
  output logic [DATA_WIDTH-1:0]    req0_read_value,
  output logic                     req0_read_valid,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [ADDRESS_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0]    req1_write_value,
  input  logic [DATA_WIDTH/8-1:0]  req1_write_sections,
  output logic [DATA_WIDTH-1:0]    req1_read_value,
  output logic                     req1_read_valid,

  output logic                     mem_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_value,
  output logic [DATA_WIDTH/8-1:0]  mem_write_sections,
  input  logic [DATA_WIDTH-1:0]    mem_read_value
);

  logic grant0;
  logic grant1;
  logic resp_owner;
  logic resp_read;

  mem_bus_grant #(
    .MAX_STREAK (MAX_STREAK)
  ) u_grant (
    .clk24      (clk24),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    mem_enable         = 1'b0;
    mem_address        = '0;
    mem_write_value    = '0;
    mem_write_sections = '0;
    if (grant0) begin
      mem_enable         = 1'b1;
      mem_address        = req0_address;
      mem_write_value    = req0_write_value;
      mem_write_sections = req0_write_sections;
    end else if (grant1) begin
      mem_enable         = 1'b1;
      mem_address        = req1_address;
      mem_write_value    = req1_write_value;
      mem_write_sections = req1_write_sections;
    end
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      resp_owner <= REQ_CPU;
      resp_read  <= 1'b0;
    end else begin
      resp_read <= mem_enable && (mem_write_sections == '0);
      if (mem_enable) begin
        resp_owner <= grant1 ? REQ_USB : REQ_CPU;
      end
    end
  end

  // Reset gates the response combinationally so a read granted just before reset is dropped.
  always_comb begin
    req0_read_valid = 1'b0;
    req1_read_valid = 1'b0;
    req0_read_value = '0;
    req1_read_value = '0;
    if (resp_read && !reset) begin
      if (resp_owner == REQ_USB) begin
        req1_read_valid = 1'b1;
        req1_read_value = mem_read_value;
      end else begin
        req0_read_valid = 1'b1;
        req0_read_value = mem_read_value;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed bench for mem_bus_arbiter with a read-response scoreboard
module tb_mem_bus_arbiter;

  logic        clk24 = 1'b0;
  logic        reset;
  logic        r0_v, r1_v;
  logic        req0_ready, req1_ready;
  logic [31:0] r0_a, r1_a, r0_d, r1_d;
  logic [3:0]  r0_s, r1_s;
  logic [31:0] req0_read_value, req1_read_value;
  logic        req0_read_valid, req1_read_valid;
  logic        mem_enable;
  logic [31:0] mem_address, mem_write_value;
  logic [3:0]  mem_write_sections;
  logic [31:0] mem_read_value = 32'h0;

  typedef struct {
    int          cyc;
    bit          owner;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    passes = 0;

  mem_bus_arbiter dut (
    .clk24               (clk24),
    .reset               (reset),
    .req0_valid          (r0_v),
    .req0_ready          (req0_ready),
    .req0_address        (r0_a),
    .req0_write_value    (r0_d),
    .req0_write_sections (r0_s),
    .req0_read_value     (req0_read_value),
    .req0_read_valid     (req0_read_valid),
    .req1_valid          (r1_v),
    .req1_ready          (req1_ready),
    .req1_address        (r1_a),
    .req1_write_value    (r1_d),
    .req1_write_sections (r1_s),
    .req1_read_value     (req1_read_value),
    .req1_read_valid     (req1_read_valid),
    .mem_enable          (mem_enable),
    .mem_address         (mem_address),
    .mem_write_value     (mem_write_value),
    .mem_write_sections  (mem_write_sections),
    .mem_read_value      (mem_read_value)
  );

  always #5 clk24 = ~clk24;
  always @(posedge clk24) cyc <= cyc + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'hC000_0004) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  // Registered memory: data for a read grant appears the following cycle, junk otherwise.
  always @(posedge clk24) begin
    if (mem_enable && mem_write_sections == 4'b0) mem_read_value <= mem_data(mem_address);
    else mem_read_value <= 32'hA5A5_A5A5;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // g: expected grant this cycle (0 none, 1 req0, 2 req1); resp: whether a read response is due.
  task automatic cycle(input int g, input bit resp, input string tag);
    logic [31:0] ea, ed;
    logic [3:0]  es;
    resp_t       r;
    @(negedge clk24);
    ea = 32'h0; ed = 32'h0; es = 4'h0;
    if (g == 1) begin ea = r0_a; ed = r0_d; es = r0_s; end
    else if (g == 2) begin ea = r1_a; ed = r1_d; es = r1_s; end
    chk({tag, ".ready0"}, req0_ready, g == 1);
    chk({tag, ".ready1"}, req1_ready, g == 2);
    chk({tag, ".enable"}, mem_enable, g != 0);
    chk({tag, ".addr"}, mem_address, ea);
    chk({tag, ".wval"}, mem_write_value, ed);
    chk({tag, ".sect"}, mem_write_sections, es);
    if (resp && g != 0 && es == 4'h0) begin
      r.cyc = cyc + 1;
      r.owner = (g == 2);
      r.data = mem_data(ea);
      exp_q.push_back(r);
    end
    @(posedge clk24);
    #1;
  endtask

  logic        e_v0, e_v1;
  logic [31:0] e_d;
  resp_t       mr;

  initial forever begin
    @(negedge clk24);
    e_v0 = 1'b0; e_v1 = 1'b0; e_d = 32'h0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mr = exp_q.pop_front();
      if (mr.owner) e_v1 = 1'b1;
      else e_v0 = 1'b1;
      e_d = mr.data;
    end
    chk("resp.valid0", req0_read_valid, e_v0);
    chk("resp.value0", req0_read_value, e_v0 ? e_d : 32'h0);
    chk("resp.valid1", req1_read_valid, e_v1);
    chk("resp.value1", req1_read_value, e_v1 ? e_d : 32'h0);
  end

  initial begin
    reset = 1'b1;
    r0_v = 1'b1; r0_a = 32'h100; r0_d = 32'h0; r0_s = 4'h0;
    r1_v = 1'b1; r1_a = 32'h200; r1_d = 32'h0; r1_s = 4'h0;
    for (int i = 0; i < 3; i++) cycle(0, 1'b1, "reset");

    reset = 1'b0;
    cycle(1, 1'b1, "first_cont");
    r0_v = 1'b0;
    cycle(2, 1'b1, "first_loser");

    r1_a = 32'hC000_0004;
    cycle(2, 1'b1, "single_read");
    r1_v = 1'b0;
    cycle(0, 1'b1, "idle");

    for (int k = 0; k < 2; k++) begin
      r0_v = 1'b1; r0_a = 32'h8000_0010; r0_d = 32'h1; r0_s = 4'b0001;
      r1_v = 1'b1; r1_a = 32'hC000_0004;
      cycle(1, 1'b1, "il_write");
      r0_v = 1'b0;
      cycle(2, 1'b1, "il_read");
    end

    r0_v = 1'b1; r0_a = 32'h8000_0010; r0_d = 32'h3; r0_s = 4'b0011;
    r1_v = 1'b1; r1_a = 32'hC000_0008; r1_s = 4'h0;
    for (int i = 0; i < 18; i++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      cycle((i % 2 == 1) ? 2 : 1, 1'b1, "rr_alt");
`else
      cycle((i % 9 == 8) ? 2 : 1, 1'b1, "starve");
`endif
    end
    r0_v = 1'b0; r1_v = 1'b0;
    cycle(0, 1'b1, "idle2");

    r0_v = 1'b1; r0_s = 4'h0; r0_d = 32'h0;
    for (int i = 0; i < 3; i++) begin
      r0_a = 32'(i * 4);
      cycle(1, 1'b1, "b2b_read");
    end
    r0_v = 1'b0;
    cycle(0, 1'b1, "b2b_tail");

    r0_v = 1'b1; r0_a = 32'h40;
    cycle(1, 1'b0, "pre_reset_read");
    r0_v = 1'b0; reset = 1'b1;
    cycle(0, 1'b0, "reset_pending");
    reset = 1'b0;
    r0_v = 1'b1; r0_a = 32'h44;
    r1_v = 1'b1; r1_a = 32'h48;
    cycle(1, 1'b1, "post_reset_cont");
    r0_v = 1'b0;
    cycle(2, 1'b1, "post_reset_loser");
    r1_v = 1'b0;
    cycle(0, 1'b1, "idle3");
    cycle(0, 1'b1, "idle4");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
